// File: rtl/theta_walker.sv
// theta_walker
//   Turns a 4-bit sector code plus a step count into a stream of unit steps
//   along a Bresenham line in that sector's representative direction, and
//   keeps a signed running (x, y) position. Feeding the emitted step direction
//   back into the 16-sector angle quantizer reproduces the same sector code.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_ready     command handshake (accepted only in IDLE)
//   i_theta               sector code: [3]=ySign, [2]=swap, [1:0]=sub-sector
//   i_len                 number of major-axis steps (0 = immediate done)
//   i_home                clears the position at the edge, IDLE only
//   o_step_valid /
//   i_step_ready          unit-step handshake
//   o_dx_en, o_dx_neg     step moves x, x move is negative
//   o_dy_en, o_dy_neg     step moves y, y move is negative
//   o_x, o_y              signed positions, two's complement
//   o_busy                walking a command
//   o_done                one-cycle pulse when a command finishes
//
// Build option
//   THETA_WALKER_SAT_EN   defined: positions saturate at the signed limits;
//                         undefined: positions wrap modulo 2^POS_BITS.

module theta_walker #(
    parameter int LEN_BITS = 8,
    parameter int POS_BITS = 12
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [3:0]          i_theta,
    input  logic [LEN_BITS-1:0] i_len,
    input  logic                i_home,
    output logic                o_step_valid,
    input  logic                i_step_ready,
    output logic                o_dx_en,
    output logic                o_dx_neg,
    output logic                o_dy_en,
    output logic                o_dy_neg,
    output logic [POS_BITS-1:0] o_x,
    output logic [POS_BITS-1:0] o_y,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [LEN_BITS-1:0]        CNT_ONE = {{(LEN_BITS-1){1'b0}}, 1'b1};
    localparam logic signed [POS_BITS-1:0] POS_ONE = {{(POS_BITS-1){1'b0}}, 1'b1};
`ifdef THETA_WALKER_SAT_EN
    localparam logic signed [POS_BITS-1:0] POS_MAX = {1'b0, {(POS_BITS-1){1'b1}}};
    localparam logic signed [POS_BITS-1:0] POS_MIN = {1'b1, {(POS_BITS-1){1'b0}}};
`endif

    // One unit move of a coordinate, wrapping or saturating by build option.
    function automatic logic signed [POS_BITS-1:0] pos_step(
        input logic signed [POS_BITS-1:0] p,
        input logic                       en,
        input logic                       neg
    );
        logic signed [POS_BITS-1:0] r;
        r = p;
        if (en) begin
`ifdef THETA_WALKER_SAT_EN
            if (neg) r = (p == POS_MIN) ? p : p - POS_ONE;
            else     r = (p == POS_MAX) ? p : p + POS_ONE;
`else
            r = neg ? p - POS_ONE : p + POS_ONE;
`endif
        end
        return r;
    endfunction

    state_t                     state;
    logic [LEN_BITS-1:0]        cnt;
    logic signed [4:0]          err;
    logic [2:0]                 maj_a;
    logic [2:0]                 min_b;
    logic                       major_x;
    logic                       x_neg;
    logic                       y_neg;
    logic signed [POS_BITS-1:0] pos_x;
    logic signed [POS_BITS-1:0] pos_y;
    logic                       done_q;

    // Command decode: representative ratio, axis swap, major/minor split.
    logic [2:0] rx, ry, abs_x, abs_y, dec_a, dec_b;
    logic       dec_major_x;

    always_comb begin
        rx = 3'd0;
        ry = 3'd0;
        case (i_theta[1:0])
            2'd0: begin rx = 3'd5; ry = 3'd1; end
            2'd1: begin rx = 3'd3; ry = 3'd2; end
            2'd2: begin rx = 3'd2; ry = 3'd3; end
            2'd3: begin rx = 3'd1; ry = 3'd5; end
            default: begin rx = 3'd0; ry = 3'd0; end
        endcase
    end

    assign abs_x       = i_theta[2] ? ry : rx;
    assign abs_y       = i_theta[2] ? rx : ry;
    assign dec_major_x = abs_x > abs_y;
    assign dec_a       = dec_major_x ? abs_x : abs_y;
    assign dec_b       = dec_major_x ? abs_y : abs_x;

    // Bresenham decision from the registered error term. Six bits hold
    // err+b (max 7) and seven bits hold its double for the compare with a.
    logic signed [5:0] e_next;
    logic signed [6:0] e_dbl;
    logic signed [5:0] e_upd;
    logic              minor_move;
    logic              run;

    assign e_next     = {err[4], err} + $signed({3'b000, min_b});
    assign e_dbl      = {e_next, 1'b0};
    assign minor_move = e_dbl >= $signed({4'b0000, maj_a});
    assign e_upd      = minor_move ? e_next - $signed({3'b000, maj_a}) : e_next;

    assign run          = (state == S_RUN);
    assign o_ready      = ~run;
    assign o_busy       = run;
    assign o_done       = done_q;
    assign o_step_valid = run;
    assign o_dx_en      = run & (major_x | minor_move);
    assign o_dy_en      = run & (~major_x | minor_move);
    assign o_dx_neg     = run & x_neg;
    assign o_dy_neg     = run & y_neg;
    assign o_x          = pos_x;
    assign o_y          = pos_y;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            err     <= '0;
            maj_a   <= '0;
            min_b   <= '0;
            major_x <= 1'b0;
            x_neg   <= 1'b0;
            y_neg   <= 1'b0;
            pos_x   <= '0;
            pos_y   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_home) begin
                        pos_x <= '0;
                        pos_y <= '0;
                    end
                    if (i_valid) begin
                        major_x <= dec_major_x;
                        maj_a   <= dec_a;
                        min_b   <= dec_b;
                        x_neg   <= i_theta[3] ^ i_theta[2];
                        y_neg   <= i_theta[3];
                        err     <= '0;
                        cnt     <= i_len;
                        if (i_len == '0) done_q <= 1'b1;
                        else             state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_step_ready) begin
                        pos_x <= pos_step(pos_x, major_x | minor_move, x_neg);
                        pos_y <= pos_step(pos_y, ~major_x | minor_move, y_neg);
                        err   <= e_upd[4:0];
                        cnt   <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_theta_walker.sv
// Bench for theta_walker: directed commands, stalls, reset abort, homing,
// a wrap/saturation boundary, and random commands against a closed-form
// model (minor-axis count after k steps = round-half-up of k*b/a).

module tb_theta_walker;

    localparam int LEN_BITS = 8;
    localparam int POS_BITS = 12;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_valid;
    logic                o_ready;
    logic [3:0]          i_theta;
    logic [LEN_BITS-1:0] i_len;
    logic                i_home;
    logic                o_step_valid;
    logic                i_step_ready;
    logic                o_dx_en, o_dx_neg, o_dy_en, o_dy_neg;
    logic [POS_BITS-1:0] o_x, o_y;
    logic                o_busy, o_done;

    theta_walker #(.LEN_BITS(LEN_BITS), .POS_BITS(POS_BITS)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_theta(i_theta), .i_len(i_len), .i_home(i_home),
        .o_step_valid(o_step_valid), .i_step_ready(i_step_ready),
        .o_dx_en(o_dx_en), .o_dx_neg(o_dx_neg), .o_dy_en(o_dy_en), .o_dy_neg(o_dy_neg),
        .o_x(o_x), .o_y(o_y), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int fails  = 0;
    int mx = 0;
    int my = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level direction decode: ratio table, swap, larger axis is major.
    task automatic decode(input logic [3:0] t, output int a, output int b, output bit majx);
        int rxt[4] = '{5, 3, 2, 1};
        int ryt[4] = '{1, 2, 3, 5};
        int ax, ay;
        ax = t[2] ? ryt[t[1:0]] : rxt[t[1:0]];
        ay = t[2] ? rxt[t[1:0]] : ryt[t[1:0]];
        majx = ax > ay;
        a = majx ? ax : ay;
        b = majx ? ay : ax;
    endtask

    function automatic int mstep(input int p, input bit neg);
`ifdef THETA_WALKER_SAT_EN
        if (neg) return (p == -(1 << (POS_BITS-1))) ? p : p - 1;
        else     return (p == (1 << (POS_BITS-1)) - 1) ? p : p + 1;
`else
        return neg ? p - 1 : p + 1;
`endif
    endfunction

    task automatic check_pos(input string tag);
        logic [POS_BITS-1:0] ex, ey;
        ex = mx[POS_BITS-1:0];
        ey = my[POS_BITS-1:0];
        check({tag, "_x"}, o_x, ex);
        check({tag, "_y"}, o_y, ey);
    endtask

    // Entered and left at a negedge. mode: 0 always ready, 1 random, 2 pattern 1,0,0.
    task automatic run_cmd(input logic [3:0] t, input int len, input bit home,
                           input int mode, input bit b2b);
        int a, b, k, cyc, pat, m_prev, m_k;
        bit majx, minor, edx, edy, rdy, xn, yn;
        decode(t, a, b, majx);
        xn = t[3] ^ t[2];
        yn = t[3];
        check("accept_ready", o_ready, 1);
        i_valid = 1'b1; i_theta = t; i_len = len[LEN_BITS-1:0]; i_home = home;
        @(negedge i_clk);
        i_valid = 1'b0; i_home = 1'b0;
        if (home) begin mx = 0; my = 0; end
        if (len == 0) begin
            check("len0_done", o_done, 1);
            check("len0_sv", o_step_valid, 0);
            check("len0_busy", o_busy, 0);
            check_pos("len0");
        end else begin
            k = 1; cyc = 0; pat = 0;
            while (k <= len) begin
                if (cyc > len * 8 + 20) begin
                    checks++; fails++;
                    $error("FAIL step_budget observed=%0d expected=%0d", k - 1, len);
                    break;
                end
                m_prev = (2 * (k - 1) * b + a) / (2 * a);
                m_k    = (2 * k * b + a) / (2 * a);
                minor  = (m_k != m_prev);
                edx    = majx || minor;
                edy    = !majx || minor;
                check("run_sv", o_step_valid, 1);
                check("run_busy", o_busy, 1);
                check("run_ready", o_ready, 0);
                check("run_done", o_done, 0);
                check("dx_en", o_dx_en, edx);
                check("dy_en", o_dy_en, edy);
                if (edx) check("dx_neg", o_dx_neg, xn);
                if (edy) check("dy_neg", o_dy_neg, yn);
                check_pos("run");
                if (mode == 0)      rdy = 1'b1;
                else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
                else                rdy = (pat % 3 == 0);
                pat++;
                i_step_ready = rdy;
                @(negedge i_clk);
                cyc++;
                if (rdy) begin
                    if (edx) mx = mstep(mx, xn);
                    if (edy) my = mstep(my, yn);
                    k++;
                end
            end
            i_step_ready = 1'b0;
            check("fin_done", o_done, 1);
            check("fin_busy", o_busy, 0);
            check("fin_ready", o_ready, 1);
            check("fin_sv", o_step_valid, 0);
            check_pos("fin");
        end
        if (!b2b) begin
            @(negedge i_clk);
            check("done_pulse_end", o_done, 0);
        end
    endtask

    initial begin
        logic [POS_BITS-1:0] wrap_exp;
        i_rst = 1'b1; i_valid = 1'b0; i_theta = '0; i_len = '0;
        i_home = 1'b0; i_step_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_ready", o_ready, 1);
        check("rst_x", o_x, 0);
        check("rst_y", o_y, 0);
        check("rst_sv", o_step_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_dx", o_dx_en, 0);
        check("rst_dy", o_dy_en, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Directed sector walks from home.
        run_cmd(4'b0000, 5, 1, 0, 0);
        check("t0000_x", o_x, 5);
        check("t0000_y", o_y, 1);
        run_cmd(4'b0001, 3, 1, 0, 0);
        check("t0001_x", o_x, 3);
        check("t0001_y", o_y, 2);
        run_cmd(4'b0100, 5, 1, 0, 0);
        check("t0100_x", o_x, 12'hFFF);
        check("t0100_y", o_y, 5);
        run_cmd(4'b1011, 5, 1, 0, 0);
        check("t1011_x", o_x, 12'hFFF);
        check("t1011_y", o_y, 12'hFFB);

        // Stalled handshakes.
        run_cmd(4'b0000, 4, 1, 2, 0);
        check("stall_x", o_x, 4);
        check("stall_y", o_y, 1);

        // Zero-length command, then home merged with an accept.
        run_cmd(4'b0101, 0, 0, 0, 0);
        run_cmd(4'b0110, 3, 0, 0, 0);
        run_cmd(4'b1110, 0, 1, 0, 0);
        check("home0_x", o_x, 0);
        run_cmd(4'b0110, 3, 1, 0, 0);

        // Back-to-back commands accepted during o_done.
        run_cmd(4'b1001, 4, 0, 0, 1);
        run_cmd(4'b0111, 6, 0, 1, 0);

        // Reset during RUN after two steps.
        check("abort_ready", o_ready, 1);
        i_valid = 1'b1; i_theta = 4'b0010; i_len = 8'd5; i_home = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; i_home = 1'b0; i_step_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        check("abort_pre_y", o_y, 2);
        i_step_ready = 1'b0;
        i_rst = 1'b1;
        #1;
        check("abort_x", o_x, 0);
        check("abort_y", o_y, 0);
        check("abort_ready_after", o_ready, 1);
        check("abort_sv", o_step_valid, 0);
        check("abort_done", o_done, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        mx = 0; my = 0;
        @(negedge i_clk);
        check("abort_nodone", o_done, 0);
        run_cmd(4'b0010, 5, 0, 0, 0);

        // Random commands.
        for (int i = 0; i < 25; i++) begin
            run_cmd(4'($urandom_range(0, 15)), $urandom_range(0, 20),
                    bit'($urandom_range(0, 3) == 0), 1, bit'($urandom_range(0, 1)));
        end

        // Drive x to the positive limit, then one more x step.
        run_cmd(4'b0000, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) run_cmd(4'b0000, 255, 0, 0, 1);
        run_cmd(4'b0000, 7, 0, 0, 0);
        check("lim_x", o_x, 12'h7FF);
        run_cmd(4'b0000, 1, 0, 0, 0);
`ifdef THETA_WALKER_SAT_EN
        wrap_exp = 12'h7FF;
`else
        wrap_exp = 12'h800;
`endif
        check("edge_x", o_x, wrap_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
